// File: rtl/key_feedback_driver_pkg.sv
// Shared types and helpers for the key feedback driver: FSM state encoding,
// counter width helper and the per-cycle event population count.
package key_feedback_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NUM_KEYS = 6;
    localparam int PEND_W   = 3;  // pending beep counter width, caps the queue at 7

    // Bits needed for a down-counter that is loaded with max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Number of key events raised in one cycle (0..6).
    function automatic logic [3:0] popcount6(input logic [5:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/key_feedback_driver_if.sv
// Bundle between the edge detector / board pins and the feedback driver.
// Key inputs are single-cycle strobes: every cycle a strobe is high counts as
// one event; there is no backpressure, so the driver never stalls its source.
// state and pending are read-only debug views of the beep scheduler.
interface key_feedback_driver_if;
    import key_feedback_driver_pkg::*;

    logic                sign_pos_A;
    logic                sign_pos_S;
    logic                sign_pos_W;
    logic                sign_pos_X;
    logic                sign_neg_X;
    logic                sign_pos_D;
    logic                mute;
    logic [5:0]          led;
    logic                buzzer;
    logic                busy;
    logic                beep_drop;
    state_t              state;
    logic [PEND_W-1:0]   pending;

    modport master (
        output sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_X, sign_neg_X, sign_pos_D, mute,
        input  led, buzzer, busy, beep_drop, state, pending
    );

    modport slave (
        input  sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_X, sign_neg_X, sign_pos_D, mute,
        output led, buzzer, busy, beep_drop, state, pending
    );

endinterface

// File: rtl/key_feedback_driver_led_stretch.sv
// Stretches a one-cycle event into a HOLD-cycle LED pulse. A new event while
// lit reloads the hold time, so the LED stays on without a gap.
module key_feedback_driver_led_stretch
    import key_feedback_driver_pkg::*;
#(
    parameter int unsigned HOLD = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic led
);

    localparam int W = cnt_width(int'(HOLD));
    localparam logic [W-1:0] HOLD_V = W'(HOLD);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    // Reload on event, otherwise count down to zero.
    always_comb begin
        count_next = count;
        if (trig) begin
            count_next = HOLD_V;
        end else if (count != '0) begin
            count_next = count - W'(1);
        end
    end

    // Counter and registered LED, which equals (count != 0) every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            led   <= 1'b0;
        end else begin
            count <= count_next;
            led   <= (count_next != '0);
        end
    end

endmodule

// File: rtl/key_feedback_driver.sv
// Key feedback driver: per-key LED stretchers plus a saturating beep queue
// drained by a BEEP/GAP scheduler that drives a square-wave buzzer.
module key_feedback_driver
    import key_feedback_driver_pkg::*;
#(
    parameter int unsigned LED_HOLD  = 20000000,
    parameter int unsigned BEEP_LEN  = 10000000,
    parameter int unsigned BEEP_GAP  = 5000000,
    parameter int unsigned TONE_HALF = 25000,
    parameter int unsigned QUEUE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 buttom_rst,
    key_feedback_driver_if.slave bus
);

    localparam int unsigned TMAX = (BEEP_LEN > BEEP_GAP) ? BEEP_LEN : BEEP_GAP;
    localparam int TW  = cnt_width(int'(TMAX));
    localparam int HW  = cnt_width(int'(TONE_HALF));
    localparam logic [TW-1:0]     LEN_V  = TW'(BEEP_LEN);
    localparam logic [TW-1:0]     GAP_V  = TW'(BEEP_GAP);
    localparam logic [HW-1:0]     HALF_V = HW'(TONE_HALF);
    localparam logic [3:0]        QMAX4  = 4'(QUEUE_MAX);
    localparam logic [PEND_W-1:0] QMAX3  = PEND_W'(QUEUE_MAX);

    logic [5:0]        events;
    logic [5:0]        led_w;
    state_t            state, state_next;
    logic [TW-1:0]     timer, timer_next;
    logic [HW-1:0]     tone, tone_next;
    logic              phase, phase_next;
    logic              dec;
    logic [PEND_W-1:0] pending, pending_next;
    logic [3:0]        pend_sum;
    logic              drop_next;
    logic              busy_next;
    logic              busy_q;
    logic              drop_q;

    assign events = {bus.sign_pos_D, bus.sign_neg_X, bus.sign_pos_X,
                     bus.sign_pos_W, bus.sign_pos_S, bus.sign_pos_A};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_led
        key_feedback_driver_led_stretch #(.HOLD(LED_HOLD)) u_stretch (
            .clk  (clk),
            .rst  (buttom_rst),
            .trig (events[i]),
            .led  (led_w[i])
        );
    end

    // Scheduler: starts a beep whenever one is pending and the buzzer is free,
    // times beep and gap, and toggles the tone phase every TONE_HALF cycles.
    always_comb begin
        state_next = state;
        timer_next = timer;
        tone_next  = tone;
        phase_next = phase;
        dec        = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = BEEP;
                    timer_next = LEN_V;
                    tone_next  = HALF_V;
                    phase_next = 1'b1;
                    dec        = 1'b1;
                end
            end
            BEEP: begin
                timer_next = timer - TW'(1);
                if (tone == HW'(1)) begin
                    phase_next = ~phase;
                    tone_next  = HALF_V;
                end else begin
                    tone_next  = tone - HW'(1);
                end
                if (timer == TW'(1)) begin
                    state_next = GAP;
                    timer_next = GAP_V;
                    phase_next = 1'b0;
                end
            end
            GAP: begin
                timer_next = timer - TW'(1);
                if (timer == TW'(1)) begin
                    if (pending != '0) begin
                        state_next = BEEP;
                        timer_next = LEN_V;
                        tone_next  = HALF_V;
                        phase_next = 1'b1;
                        dec        = 1'b1;
                    end else begin
                        state_next = IDLE;
                        timer_next = '0;
                        tone_next  = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
                tone_next  = '0;
                phase_next = 1'b0;
            end
        endcase
    end

    // Queue update: consume the started beep and add this cycle's events,
    // saturating at QUEUE_MAX and flagging the events that did not fit.
    always_comb begin
        pend_sum     = {1'b0, pending} - {3'b000, dec} + popcount6(events);
        drop_next    = (pend_sum > QMAX4);
        pending_next = drop_next ? QMAX3 : pend_sum[PEND_W-1:0];
        busy_next    = (state_next != IDLE) || (pending_next != '0);
    end

    // State register; reset wins over everything, including a running beep.
    always_ff @(posedge clk) begin
        if (buttom_rst) begin
            state   <= IDLE;
            timer   <= '0;
            tone    <= '0;
            phase   <= 1'b0;
            pending <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            tone    <= tone_next;
            phase   <= phase_next;
            pending <= pending_next;
            busy_q  <= busy_next;
            drop_q  <= drop_next;
        end
    end

    // phase is only ever high inside BEEP, so it alone gates the tone.
    assign bus.buzzer    = phase & ~bus.mute;
    assign bus.led       = led_w;
    assign bus.busy      = busy_q;
    assign bus.beep_drop = drop_q;
    assign bus.state     = state;
    assign bus.pending   = pending;

endmodule

// File: tb/tb_key_feedback_driver.sv
// Bench for key_feedback_driver with short timing parameters. A timeline model
// (event timestamps, beep start times) predicts every output each cycle, and a
// table of hand-derived literal values pins that model at key cycles.
module tb_key_feedback_driver;
    import key_feedback_driver_pkg::*;

    localparam int HOLD  = 8;
    localparam int LEN   = 6;
    localparam int GAP_C = 3;
    localparam int TH    = 2;
    localparam int QMAX  = 3;
    localparam int NCYC  = 272;

    localparam int S_LED   = 0;
    localparam int S_BUZ   = 1;
    localparam int S_BUSY  = 2;
    localparam int S_DROP  = 3;
    localparam int S_PEND  = 4;
    localparam int S_STATE = 5;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } lit_t;

    // ---------------- clock / reset / stimulus signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ev;
    logic       mute;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    logic [5:0] st_ev[NCYC];
    logic       st_mute[NCYC];
    logic       st_rst[NCYC];
    lit_t       lit_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    key_feedback_driver_if bus();

    assign bus.sign_pos_A = ev[0];
    assign bus.sign_pos_S = ev[1];
    assign bus.sign_pos_W = ev[2];
    assign bus.sign_pos_X = ev[3];
    assign bus.sign_neg_X = ev[4];
    assign bus.sign_pos_D = ev[5];
    assign bus.mute       = mute;

    key_feedback_driver #(
        .LED_HOLD  (HOLD),
        .BEEP_LEN  (LEN),
        .BEEP_GAP  (GAP_C),
        .TONE_HALF (TH),
        .QUEUE_MAX (QMAX)
    ) dut (
        .clk        (clk),
        .buttom_rst (rst),
        .bus        (bus)
    );

    // ---------------- behavioural model ----------------
    int         last_ev[6] = '{default: -1000};
    int         beep_start = -1000;
    int         m_pend = 0;
    logic [5:0] m_led = '0;
    logic       m_tone = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_drop = 1'b0;
    state_t     m_state = IDLE;

    // Predict outputs for the cycle after each edge from the inputs it sampled.
    always @(posedge clk) begin
        int  t;
        int  u;
        int  raw;
        int  dec_now;
        bit  in_beep;
        bit  in_gap;
        t = cyc;
        m_drop = 1'b0;
        if (rst) begin
            for (int i = 0; i < 6; i++) last_ev[i] = -1000;
            beep_start = -1000;
            m_pend = 0;
        end else begin
            for (int i = 0; i < 6; i++) if (ev[i]) last_ev[i] = t;
            // The buzzer is free once the previous beep reached the last gap cycle.
            dec_now = ((t >= beep_start + LEN + GAP_C - 1) && (m_pend > 0)) ? 1 : 0;
            if (dec_now == 1) beep_start = t + 1;
            raw = m_pend - dec_now + $countones(ev);
            m_drop = (raw > QMAX);
            m_pend = (raw > QMAX) ? QMAX : raw;
        end
        u = t + 1;
        for (int i = 0; i < 6; i++) m_led[i] = ((u - last_ev[i]) >= 1) && ((u - last_ev[i]) <= HOLD);
        in_beep = (u >= beep_start) && (u <= beep_start + LEN - 1);
        in_gap  = (u >= beep_start + LEN) && (u <= beep_start + LEN + GAP_C - 1);
        m_tone  = in_beep && ((((u - beep_start) / TH) % 2) == 0);
        m_state = in_beep ? BEEP : (in_gap ? GAP : IDLE);
        m_busy  = in_beep || in_gap || (m_pend != 0);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int dut_sig(input int s);
        case (s)
            S_LED:   return int'(bus.led);
            S_BUZ:   return int'(bus.buzzer);
            S_BUSY:  return int'(bus.busy);
            S_DROP:  return int'(bus.beep_drop);
            S_PEND:  return int'(bus.pending);
            default: return int'(bus.state);
        endcase
    endfunction

    function automatic void lit(input int c, input int s, input int v);
        lit_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        lit_q.push_back(e);
    endfunction

    // Compare every cycle against the model, plus any literal pinned to this cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("led",       int'(bus.led),       int'(m_led));
            check("buzzer",    int'(bus.buzzer),    int'(m_tone & ~mute));
            check("busy",      int'(bus.busy),      int'(m_busy));
            check("beep_drop", int'(bus.beep_drop), int'(m_drop));
            check("pending",   int'(bus.pending),   m_pend);
            check("state",     int'(bus.state),     int'(m_state));
            for (int j = lit_q.size() - 1; j >= 0; j--) begin
                if (lit_q[j].cyc == cyc) begin
                    check($sformatf("literal_sig%0d", lit_q[j].sig), dut_sig(lit_q[j].sig), lit_q[j].val);
                    lit_q.delete(j);
                end
            end
        end
    end

    // ---------------- directed stimulus and driver ----------------
    initial begin
        int pat[6];
        pat = '{1, 1, 0, 0, 1, 1};
        for (int k = 0; k < NCYC; k++) begin
            st_ev[k] = '0;
            st_mute[k] = 1'b0;
            st_rst[k] = 1'b0;
        end

        // Power-on reset, then check reset state.
        st_rst[0] = 1'b1; st_rst[1] = 1'b1; st_rst[2] = 1'b1;
        lit(3, S_LED, 0); lit(3, S_BUSY, 0); lit(3, S_PEND, 0); lit(3, S_STATE, 0);

        // Single A pulse: LED 11..18, beep 12..17, gap 18..20, idle at 21.
        st_ev[10] = 6'h01;
        lit(10, S_LED, 0); lit(11, S_LED, 1); lit(18, S_LED, 1); lit(19, S_LED, 0);
        lit(11, S_BUZ, 0);
        for (int k = 0; k < 6; k++) lit(12 + k, S_BUZ, pat[k]);
        lit(18, S_STATE, 2); lit(20, S_STATE, 2); lit(21, S_STATE, 0);
        lit(20, S_BUSY, 1); lit(21, S_BUSY, 0);

        // W retriggered while lit: led[2] continuous 51..63.
        st_ev[50] = 6'h04; st_ev[55] = 6'h04;
        for (int k = 51; k <= 63; k++) lit(k, S_LED, 4);
        lit(64, S_LED, 0);

        // Three events on consecutive cycles: beeps at 92, 101, 110; idle at 119.
        st_ev[90] = 6'h01; st_ev[91] = 6'h02; st_ev[92] = 6'h20;
        lit(93, S_LED, 'h23); lit(93, S_PEND, 2); lit(100, S_STATE, 2);
        lit(101, S_PEND, 1); lit(110, S_PEND, 0); lit(110, S_STATE, 1);
        lit(118, S_BUSY, 1); lit(119, S_BUSY, 0);

        // All six keys at once: saturate at 3, one drop pulse, three beeps.
        st_ev[140] = 6'h3F;
        lit(141, S_LED, 'h3F); lit(148, S_LED, 'h3F); lit(149, S_LED, 0);
        lit(141, S_DROP, 1); lit(142, S_DROP, 0);
        lit(141, S_PEND, 3); lit(142, S_PEND, 2); lit(160, S_PEND, 0);
        lit(160, S_BUZ, 1); lit(162, S_BUZ, 0);
        lit(168, S_STATE, 2); lit(169, S_STATE, 0); lit(169, S_BUSY, 0);

        // Mute over the second beep (201..206): silent, timing unchanged.
        st_ev[190] = 6'h01; st_ev[191] = 6'h02;
        for (int k = 201; k <= 206; k++) st_mute[k] = 1'b1;
        lit(192, S_BUZ, 1); lit(201, S_BUZ, 0); lit(205, S_BUZ, 0);
        lit(201, S_STATE, 1); lit(207, S_STATE, 2);
        lit(209, S_BUSY, 1); lit(210, S_BUSY, 0);

        // Reset in the middle of a beep with one beep still queued.
        st_ev[230] = 6'h01; st_ev[233] = 6'h01; st_rst[234] = 1'b1;
        lit(233, S_BUZ, 1); lit(234, S_PEND, 1); lit(234, S_STATE, 1);
        lit(235, S_LED, 0); lit(235, S_BUZ, 0); lit(235, S_BUSY, 0);
        lit(235, S_PEND, 0); lit(235, S_STATE, 0);
        st_ev[245] = 6'h01;
        lit(246, S_LED, 1); lit(247, S_BUZ, 1); lit(253, S_STATE, 2); lit(256, S_BUSY, 0);

        ev   = st_ev[0];
        mute = st_mute[0];
        rst  = st_rst[0];
        while (cyc < NCYC - 1) begin
            @(posedge clk);
            #1;
            ev   = st_ev[cyc];
            mute = st_mute[cyc];
            rst  = st_rst[cyc];
        end
        @(negedge clk);
        #1;
        if (lit_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL literal_unreached: got %0d pending expected 0", lit_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
